// File: rtl/data_mem_responder_if.sv
// Request/response bus between a load/store requester and a word-organised
// memory responder. Two independent valid/ready handshakes: one carries the
// request towards memory, the other carries data and an error flag back.
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  // Requester side (datapath memory port).
  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  // Responder side (memory).
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Fixed-latency data memory responder. Accepts one word read or write at a
// time, commits it against an internal 32-bit word array LATENCY edges after
// acceptance, then presents data and an error flag until the requester takes
// the response. Misaligned or out-of-range byte addresses never touch the array.
module data_mem_responder #(
  parameter int ADDR_W  = 8,  // word-index width; depth is 2**ADDR_W words
  parameter int LATENCY = 2   // accept-to-response edges, legal 1..15
) (
  input  logic                 clk,
  input  logic                 rst,   // asynchronous, active low
  data_mem_responder_if.slave  bus,
  output logic                 busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               write_q;
  logic [31:0]        addr_q;
  logic [31:0]        wdata_q;
  logic [31:0]        rdata_q;
  logic               err_q;
  logic [31:0]        mem [DEPTH];

  logic               accept;
  logic               commit;
  logic               addr_err;
  logic [ADDR_W-1:0]  word_idx;

  // The request is judged on the latched address, so the requester may
  // change req_addr freely once the request has been accepted.
  assign addr_err = (addr_q[1:0] != 2'b00) || (addr_q[31:ADDR_W+2] != '0);
  assign word_idx = addr_q[ADDR_W+1:2];

  // Next-state and handshake outputs; accept and commit are single-edge strobes.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    state_d       = state_q;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    accept        = 1'b0;
    commit        = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          accept  = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // With LATENCY=1 the counter is loaded with 0, so the very next edge
        // commits and the response appears one cycle after acceptance.
        if (cnt_q == '0) begin
          commit  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset drops any in-flight request immediately.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Request capture, latency countdown and response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        write_q <= bus.req_write;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        cnt_q   <= CNT_W'(LATENCY - 1);
      end else if (state_q == WAIT && cnt_q != '0) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      // Loads read the array as it stood before this edge; stores and
      // errored requests always return zero data.
      if (commit) begin
        rdata_q <= (addr_err || write_q) ? '0 : mem[word_idx];
        err_q   <= addr_err;
      end
    end
  end

  // Word array write port; only a committing, in-range store writes.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; contents are
    // undefined until written, and reset only aborts the control path.
    if (commit && write_q && !addr_err) mem[word_idx] <= wdata_q;
  end

  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign busy          = (state_q != IDLE);

endmodule
